// File: rtl/board_controller_if.sv
// Move handshake bundle for board_controller: a mover offers a cell and a side,
// the controller answers with mv_ready.
interface board_controller_if #(
  parameter int N = 3
) ();
  localparam int RW = $clog2(N);

  logic          mv_valid;
  logic          mv_ready;
  logic [1:0]    mv_xoro;
  logic [RW-1:0] mv_row;
  logic [RW-1:0] mv_col;

  modport master (output mv_valid, mv_xoro, mv_row, mv_col, input mv_ready);
  modport slave  (input mv_valid, mv_xoro, mv_row, mv_col, output mv_ready);
endinterface

// File: rtl/board_controller.sv
// N x N noughts-and-crosses referee: validates moves, scans one line per cycle
// for a win or draw, and streams the board out one cell per cycle.
module board_controller #(
  parameter  int N  = 3,
  localparam int RW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_game,
  board_controller_if.slave     mv,
  output logic                  err,
  output logic [2:0]            err_code,
  output logic [1:0]            turn,
  output logic [1:0]            win,
  output logic [RW-1:0]         scan_row,
  output logic [RW-1:0]         scan_col,
  output logic [1:0]            scan_xoro
);
  localparam int CELLS = N * N;
  localparam int CIW   = $clog2(CELLS);
  localparam int CW    = $clog2(CELLS + 1);
  localparam int LW    = $clog2(2 * N + 2);

  typedef enum logic [1:0] {IDLE = 2'd0, CHECK = 2'd1, OVER = 2'd2} state_t;

  state_t                  state;
  logic                    ready;
  logic [CELLS-1:0][1:0]   board;
  logic [CELLS-1:0][1:0]   board_next;
  logic [CW-1:0]           count;
  logic [1:0]              last;
  logic [LW-1:0]           line;
  logic                    hs;
  logic                    parse_bad;
  logic                    accept;
  logic                    hit;
  logic [2:0]              code;
  logic [CIW-1:0]          cell_sel;
  logic [CIW-1:0]          next_idx;
  logic [RW-1:0]           next_row;
  logic [RW-1:0]           next_col;
  int                      cidx;

  assign mv.mv_ready = ready;
  assign hs          = mv.mv_valid & ready;
  assign parse_bad   = (int'(mv.mv_row) >= N) || (int'(mv.mv_col) >= N) ||
                       (mv.mv_xoro == 2'b00) || (mv.mv_xoro == 2'b11);
  assign accept      = hs && !new_game && (code == 3'd0);

  // Move classification, highest-priority reason first
  always_comb begin
    cell_sel = '0;
    if (parse_bad) begin
      cell_sel = '0;
    end else begin
      cell_sel = CIW'(int'(mv.mv_row) * N + int'(mv.mv_col));
    end
    code = 3'd0;
    if (state == OVER) begin
      code = 3'd4;
    end else if (parse_bad) begin
      code = 3'd1;
    end else if (mv.mv_xoro != turn) begin
      code = 3'd2;
    end else if (board[cell_sel] != 2'b00) begin
      code = 3'd3;
    end else begin
      code = 3'd0;
    end
  end

  // Board contents after this edge, so the scanner never shows a stale cell
  always_comb begin
    board_next = board;
    if (new_game) begin
      board_next = '0;
    end else if (accept) begin
      board_next[cell_sel] = mv.mv_xoro;
    end else begin
      board_next = board;
    end
  end

  // Line under test: rows, then columns, then main and anti diagonal
  always_comb begin
    hit  = 1'b1;
    cidx = 0;
    for (int k = 0; k < N; k++) begin
      if (int'(line) < N) begin
        cidx = int'(line) * N + k;
      end else if (int'(line) < 2 * N) begin
        cidx = k * N + (int'(line) - N);
      end else if (int'(line) == 2 * N) begin
        cidx = k * N + k;
      end else begin
        cidx = k * N + (N - 1 - k);
      end
      if (board[CIW'(cidx)] != last) begin
        hit = 1'b0;
      end else begin
        hit = hit;
      end
    end
  end

  // Row-major scanner position for the next cycle
  always_comb begin
    next_row = scan_row;
    next_col = scan_col + RW'(1);
    if (scan_col == RW'(N - 1)) begin
      next_col = '0;
      if (scan_row == RW'(N - 1)) begin
        next_row = '0;
      end else begin
        next_row = scan_row + RW'(1);
      end
    end else begin
      next_row = scan_row;
    end
    next_idx = CIW'(int'(next_row) * N + int'(next_col));
  end

  // Game FSM, board storage and scanner registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ready     <= 1'b1;
      board     <= '0;
      count     <= '0;
      last      <= 2'b00;
      line      <= '0;
      turn      <= 2'b01;
      win       <= 2'b00;
      err       <= 1'b0;
      err_code  <= 3'd0;
      scan_row  <= '0;
      scan_col  <= '0;
      scan_xoro <= 2'b00;
    end else begin
      scan_row  <= next_row;
      scan_col  <= next_col;
      scan_xoro <= board_next[next_idx];
      board     <= board_next;
      err       <= 1'b0;
      if (new_game) begin
        state    <= IDLE;
        ready    <= 1'b1;
        count    <= '0;
        line     <= '0;
        turn     <= 2'b01;
        win      <= 2'b00;
        err_code <= 3'd0;
      end else begin
        case (state)
          IDLE, OVER: begin
            if (hs && (code != 3'd0)) begin
              err      <= 1'b1;
              err_code <= code;
            end else if (hs) begin
              count    <= count + CW'(1);
              turn     <= ~turn;
              last     <= mv.mv_xoro;
              err_code <= 3'd0;
              line     <= '0;
              state    <= CHECK;
              ready    <= 1'b0;
            end else begin
              state <= state;
            end
          end
          CHECK: begin
            if (hit) begin
              win   <= last;
              state <= OVER;
              ready <= 1'b1;
            end else if (line == LW'(2 * N + 1)) begin
              ready <= 1'b1;
              if (count == CW'(CELLS)) begin
                win   <= 2'b11;
                state <= OVER;
              end else begin
                state <= IDLE;
              end
            end else begin
              line <= line + LW'(1);
            end
          end
          default: begin
            state <= IDLE;
            ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule
